dcache_port_arbiter: RTL and testbench

- Sits directly downstream of store_buffer_top and upstream of the dcache.
- Owns the single dcache request port and arbitrates between store-buffer drain writes (stb2dcache_*) and LSU load reads.
- Enforces drain-before-load ordering: a load is issued only when the store buffer reports empty.
- Returns the dcache acknowledge to the winner, and flags ack timeouts.

---
 rtl/dcache_arb_pkg.sv | 28 ++
 rtl/dcache_port_arbiter_timeout.sv | 33 +++
 rtl/dcache_port_arbiter.sv | 114 +++++++++++
 tb/tb_dcache_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// dcache port arbiter shared types.
// Request bundle, FSM state and owner encodings.
package dcache_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ST_REQ,
        LD_REQ,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_STB,
        OWN_LSU
    } arb_owner_e;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_SEL_W-1:0]  sel_byte;
        logic                  w_en;
    } arb_req_t;

endpackage

// File: rtl/dcache_port_arbiter_timeout.sv
// Saturating ack-wait counter with a sticky error flag.
// Holds at LIMIT-1 once reached; err only clears on reset.
module arb_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic err
);

    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single dcache port shared by store-buffer drains and LSU loads.
// Loads only win when the store buffer is empty (drain-before-load).
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int BYTE_SEL_WIDTH = ARB_SEL_W,
    parameter int ACK_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_w_en,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_empty,
    input  logic [ADDR_WIDTH-1:0]     lsudbus2arb_addr,
    input  logic                      lsudbus2arb_req,
    output logic                      arb2stb_ack,
    output logic                      arb2lsudbus_ack,
    output logic [DATA_WIDTH-1:0]     arb2lsudbus_rdata,
    output logic                      arb2lsudbus_stall,
    output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
    output logic                      arb2dcache_w_en,
    output logic                      arb2dcache_req,
    input  logic                      dcache2arb_ack,
    input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
    output logic                      arb_timeout_err
);

    arb_state_e state;
    arb_owner_e owner;
    arb_req_t   req_q;
    logic       in_req;

    assign in_req = (state == ST_REQ) || (state == LD_REQ);

    assign arb2dcache_addr     = req_q.addr;
    assign arb2dcache_wdata    = req_q.wdata;
    assign arb2dcache_sel_byte = req_q.sel_byte;
    assign arb2dcache_w_en     = req_q.w_en;

    assign arb2lsudbus_stall = lsudbus2arb_req &&
        !(state == RESP && owner == OWN_LSU);

    arb_timeout_cnt #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_req),
        .en    (in_req && !dcache2arb_ack),
        .err   (arb_timeout_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= OWN_STB;
            req_q             <= '0;
            arb2dcache_req    <= 1'b0;
            arb2stb_ack       <= 1'b0;
            arb2lsudbus_ack   <= 1'b0;
            arb2lsudbus_rdata <= '0;
        end else begin
            arb2stb_ack     <= 1'b0;
            arb2lsudbus_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (lsudbus2arb_req && stb2dcache_empty) begin
                        state          <= LD_REQ;
                        owner          <= OWN_LSU;
                        req_q.addr     <= lsudbus2arb_addr;
                        req_q.wdata    <= '0;
                        req_q.sel_byte <= '1;
                        req_q.w_en     <= 1'b0;
                        arb2dcache_req <= 1'b1;
                    end else if (stb2dcache_req) begin
                        state          <= ST_REQ;
                        owner          <= OWN_STB;
                        req_q.addr     <= stb2dcache_addr;
                        req_q.wdata    <= stb2dcache_wdata;
                        req_q.sel_byte <= stb2dcache_sel_byte;
                        req_q.w_en     <= stb2dcache_w_en;
                        arb2dcache_req <= 1'b1;
                    end
                end
                ST_REQ, LD_REQ: begin
                    if (dcache2arb_ack) begin
                        arb2dcache_req <= 1'b0;
                        state          <= RESP;
                        if (owner == OWN_LSU) begin
                            arb2lsudbus_rdata <= dcache2arb_rdata;
                            arb2lsudbus_ack   <= 1'b1;
                        end else begin
                            arb2stb_ack <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized bench for dcache_port_arbiter against a transaction model.
// Requester agents, a dcache responder and a reference memory.
module tb_dcache_port_arbiter;

    localparam int T = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } st_txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_wdata = '0;
    logic [3:0]  st_sel = '0;
    logic        st_wen = 1'b0;
    logic        st_req = 1'b0;
    logic        empty = 1'b1;
    logic [31:0] ld_addr = '0;
    logic        ld_req = 1'b0;
    logic        dack = 1'b0;
    logic [31:0] drdata = '0;

    logic        stb_ack, lsu_ack, stall, dreq, dwen, err;
    logic [31:0] lsu_rdata, daddr, dwdata;
    logic [3:0]  dsel;

    int errors = 0;
    int checks = 0;

    // model of the port
    bit          m_wait, m_resp, m_ld, m_wen, m_err, m_sa, m_la;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_sel;
    int          m_cnt;

    // agents / responder control
    st_txn_t     st_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] refmem[logic [31:0]];
    bit          rnd_en = 0, spur = 0, hold_empty = 0, seen = 0;
    int          ack_delay = 2, dcnt = 0, nst = 0, nld = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BYTE_SEL_WIDTH (4),
        .ACK_TIMEOUT    (T)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .stb2dcache_addr     (st_addr),
        .stb2dcache_wdata    (st_wdata),
        .stb2dcache_sel_byte (st_sel),
        .stb2dcache_w_en     (st_wen),
        .stb2dcache_req      (st_req),
        .stb2dcache_empty    (empty),
        .lsudbus2arb_addr    (ld_addr),
        .lsudbus2arb_req     (ld_req),
        .arb2stb_ack         (stb_ack),
        .arb2lsudbus_ack     (lsu_ack),
        .arb2lsudbus_rdata   (lsu_rdata),
        .arb2lsudbus_stall   (stall),
        .arb2dcache_addr     (daddr),
        .arb2dcache_wdata    (dwdata),
        .arb2dcache_sel_byte (dsel),
        .arb2dcache_w_en     (dwen),
        .arb2dcache_req      (dreq),
        .dcache2arb_ack      (dack),
        .dcache2arb_rdata    (drdata),
        .arb_timeout_err     (err)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                          logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rdref(logic [31:0] a);
        return refmem.exists(a) ? refmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rdmem(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_resp = 0; m_ld = 0; m_wen = 0; m_err = 0;
        m_sa = 0; m_la = 0; m_cnt = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_sel = '0;
    endtask

    // one clock: model step + output checks + dcache responder
    task automatic tick();
        logic s_st, s_ld, s_emp, s_ack, s_sw;
        logic [31:0] s_sa, s_sd, s_la, s_rd;
        logic [3:0] s_ss;
        s_st = st_req; s_ld = ld_req; s_emp = empty; s_ack = dack;
        s_sw = st_wen; s_sa = st_addr; s_sd = st_wdata; s_la = ld_addr;
        s_rd = drdata; s_ss = st_sel;
        @(negedge clk);
        m_sa = 0;
        m_la = 0;
        if (m_resp) begin
            m_resp = 0;
        end else if (m_wait) begin
            if (s_ack) begin
                m_wait = 0;
                m_resp = 1;
                if (m_ld) begin
                    m_rdata = s_rd;
                    m_la = 1;
                end else begin
                    m_sa = 1;
                end
            end else begin
                m_cnt++;
                if (m_cnt >= T) m_err = 1;
            end
        end else if (s_ld && s_emp) begin
            m_wait = 1; m_ld = 1; m_cnt = 0;
            m_addr = s_la; m_wdata = '0; m_sel = 4'hf; m_wen = 0;
        end else if (s_st) begin
            m_wait = 1; m_ld = 0; m_cnt = 0;
            m_addr = s_sa; m_wdata = s_sd; m_sel = s_ss; m_wen = s_sw;
        end
        chk("dreq", dreq, m_wait);
        chk("stb_ack", stb_ack, m_sa);
        chk("lsu_ack", lsu_ack, m_la);
        chk("err", err, m_err);
        chk("lsu_rdata", lsu_rdata, m_rdata);
        chk("stall", stall, s_ld && !m_la);
        if (m_wait) begin
            chk("daddr", daddr, m_addr);
            chk("dwdata", dwdata, m_wdata);
            chk("dsel", dsel, m_sel);
            chk("dwen", dwen, m_wen);
        end
        if (dack) begin
            dack = 0;
            drdata = $urandom;
        end else if (dreq) begin
            if (!seen) begin
                seen = 1;
                dcnt = (ack_delay < 0) ? $urandom_range(0, 3) : ack_delay;
            end
            drdata = $urandom;
            if (dcnt == 0) begin
                dack = 1;
                seen = 0;
                if (dwen) mem[daddr] = merge(rdmem(daddr), dwdata, dsel);
                else drdata = rdmem(daddr);
            end else begin
                dcnt--;
            end
        end else begin
            seen = 0;
            drdata = $urandom;
            if (spur && $urandom_range(0, 5) == 0) dack = 1;
        end
    endtask

    task automatic agents();
        st_txn_t t;
        if (st_req && stb_ack) begin
            refmem[st_addr] = merge(rdref(st_addr), st_wdata, st_sel);
            st_req = 0;
            nst++;
            if (!hold_empty) empty = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (ld_req && lsu_ack) begin
            chk("ld_data", lsu_rdata, rdref(ld_addr));
            ld_req = 0;
            nld++;
        end
        if (rnd_en) begin
            if (!empty && !st_req && !hold_empty && $urandom_range(0, 2) == 0)
                empty = 1;
            if (st_q.size() == 0 && !st_req && $urandom_range(0, 2) == 0) begin
                t.addr = 32'h1000 + ($urandom_range(0, 7) << 2);
                t.data = $urandom;
                t.sel = 4'($urandom_range(1, 15));
                st_q.push_back(t);
            end
            if (ld_q.size() == 0 && !ld_req && $urandom_range(0, 2) == 0)
                ld_q.push_back(32'h1000 + ($urandom_range(0, 7) << 2));
        end
        if (!st_req && st_q.size() > 0) begin
            t = st_q.pop_front();
            st_addr = t.addr; st_wdata = t.data; st_sel = t.sel;
            st_wen = 1; st_req = 1; empty = 0;
        end
        if (!ld_req && ld_q.size() > 0) begin
            ld_addr = ld_q.pop_front();
            ld_req = 1;
        end
    endtask

    task automatic cycle();
        tick();
        agents();
    endtask

    task automatic drain(string tag, int budget);
        int n;
        n = 0;
        while ((st_req || ld_req || st_q.size() > 0 || ld_q.size() > 0)
               && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, st_req || ld_req, 0);
        cycle();
        cycle();
    endtask

    task automatic push_st(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        st_txn_t t;
        t.addr = a; t.data = d; t.sel = s;
        st_q.push_back(t);
    endtask

    task automatic bench_reset();
        st_req = 0; ld_req = 0; empty = 1; dack = 0; seen = 0;
        st_q.delete(); ld_q.delete();
        model_reset();
    endtask

    initial begin
        int n0, n;
        model_reset();
        ld_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_dreq", dreq, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dwdata", dwdata, 0);
        chk("rst_dsel", dsel, 0);
        chk("rst_dwen", dwen, 0);
        chk("rst_acks", {stb_ack, lsu_ack}, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 1);
        ld_req = 0;
        #1;
        chk("rst_stall_lo", stall, 0);
        @(negedge clk);
        rst_n = 1;

        // store only
        ack_delay = 2;
        n0 = nst;
        push_st(32'h1000, 32'hAAAA_BBBB, 4'hf);
        drain("store_done", 20);
        chk("store_cnt", nst - n0, 1);

        // load with empty store buffer
        mem[32'h2000] = 32'hDEAD_BEEF;
        refmem[32'h2000] = 32'hDEAD_BEEF;
        ld_q.push_back(32'h2000);
        drain("load_done", 20);
        chk("load_data", lsu_rdata, 32'hDEAD_BEEF);

        // drain-before-load ordering
        ack_delay = 1;
        hold_empty = 1;
        ld_q.push_back(32'h1004);
        push_st(32'h1004, 32'h1234_5678, 4'hf);
        agents();
        n = 0;
        while (st_req && n < 20) begin
            cycle();
            n++;
        end
        chk("order_st_first", ld_req, 1);
        repeat (4) cycle();
        chk("order_ld_held", ld_req, 1);
        hold_empty = 0;
        empty = 1;
        drain("order_done", 20);
        chk("order_ld_data", lsu_rdata, 32'h1234_5678);

        // back-to-back stores
        n0 = nst;
        for (int i = 0; i < 4; i++)
            push_st(32'h1000 + 32'(i * 4), $urandom, 4'hf);
        drain("b2b_done", 60);
        chk("b2b_cnt", nst - n0, 4);

        // randomized traffic
        ack_delay = -1;
        spur = 1;
        rnd_en = 1;
        repeat (1500) cycle();
        rnd_en = 0;
        empty = st_req ? 1'b0 : 1'b1;
        drain("rnd_done", 80);
        if (!st_req) empty = 1;
        drain("rnd_done2", 80);
        spur = 0;

        // ack timeout
        ack_delay = 12;
        push_st(32'h1100, 32'h0BAD_F00D, 4'h3);
        drain("tmo_done", 40);
        chk("tmo_err_sticky", err, 1);

        // reset during a load
        ack_delay = 30;
        empty = 1;
        ld_q.push_back(32'h1008);
        n = 0;
        while (!(m_wait && m_ld) && n < 10) begin
            cycle();
            n++;
        end
        chk("mid_in_load", dreq, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_dreq", dreq, 0);
        chk("mid_rst_acks", {stb_ack, lsu_ack}, 0);
        chk("mid_rst_err", err, 0);
        bench_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        ack_delay = 2;
        n0 = nst;
        push_st(32'h1010, 32'h5555_AAAA, 4'hf);
        drain("post_rst_done", 20);
        chk("post_rst_cnt", nst - n0, 1);
        chk("post_rst_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
